dpram_be_clr: RTL
=================

DPRAM_BE_CLR -- requirements
Module: dpram_be_clr

Interface
REQ-001 Parameter AW, default 8: address width; depth is 2^AW words.
REQ-002 Parameter DW, default 32: data width; SHALL be a multiple of 8; NB = DW/8 byte lanes.
REQ-003 Parameter LAT, default 2: read latency in cycles; legal values 1 or 2.
REQ-004 clock  input  1  single clock; all logic on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ready  output  1  high when the memory accepts user accesses.
REQ-007 wren_a  input  1  port A write request.
REQ-008 be_a  input  NB  port A byte-lane enables; bit i qualifies data_a[8i+7:8i].
REQ-009 address_a  input  AW  port A word address.
REQ-010 data_a  input  DW  port A write data.
REQ-011 q_a  output  DW  port A read data.
REQ-012 wren_b, be_b, address_b, data_b, q_b: same as the port A signals, for port B.
REQ-013 collision  output  1  one-cycle pulse flagging a same-address dual write.

Function
REQ-014 Both ports read every cycle; q_x presents mem[address_x] as sampled at edge N, valid after edge N+LAT-1.
REQ-015 LAT=2 SHALL use one internal read register plus the output register; LAT=1 SHALL use the output register only.
REQ-016 A write SHALL update only the byte lanes whose be bit is 1 when wren=1 and ready=1; other lanes are retained.
REQ-017 A write with be all-zero SHALL leave memory unchanged.
REQ-018 Same-port read during write: read-first; q returns the pre-write word.
REQ-019 Cross-port read of an address being written in the same cycle SHALL return the pre-write word.
REQ-020 Both ports writing the same address in the same cycle: port A data wins on lanes enabled by both; each port writes its exclusive lanes.
REQ-021 collision SHALL be 1 in the cycle after an edge on which wren_a=wren_b=1, address_a=address_b, (be_a & be_b)!=0 and ready=1; otherwise 0.
REQ-022 Clear FSM states: CLEAR and RUN; the FSM enters CLEAR on reset.
REQ-023 In CLEAR, an AW-bit counter starting at 0 writes zero to mem[counter] through port A each cycle; user writes on both ports are ignored; ready=0.
REQ-024 CLEAR->RUN when the counter write at address 2^AW-1 completes; clear takes exactly 2^AW cycles after reset release; ready=1 from the following cycle.
REQ-025 RUN is terminal until the next reset; user reads during CLEAR SHALL be performed but results are unspecified.

Reset
REQ-026 On reset_n=0: q_a=0, q_b=0, internal read registers=0, collision=0, ready=0, counter=0, state=CLEAR.
REQ-027 Reset asserted mid-clear SHALL abort the clear; the clear SHALL restart from address 0 after release.
REQ-028 Reset SHALL NOT be applied to the memory array itself.

Configuration
REQ-029 Macro DPRAM_BE_CLR_CLEAR_EN defined: the clear FSM of REQ-022..REQ-025 is present.
REQ-030 Macro DPRAM_BE_CLR_CLEAR_EN undefined: no FSM or counter; ready goes to 1 on the first clock edge after reset release; initial memory contents are undefined; all other behaviour is unchanged.

Verification
REQ-031 Clear: AW=4 with the macro defined; release reset -> ready=0 for 16 cycles, then 1; reads of all 16 addresses return 0.
REQ-032 Byte enables: write 0x11223344 to address 5, then write be=4'b0101, data 0xAABBCCDD to address 5 -> read returns 0x11BB33DD.
REQ-033 Latency: LAT=2; present address 7 (holding 0xCAFEF00D) at edge N -> q_a=0xCAFEF00D after edge N+1, not after edge N; LAT=1 -> valid after edge N.
REQ-034 Collision: A writes 0x000000FF with be=4'b0011, B writes 0xFFFF0000 with be=4'b1111, both to address 3 -> mem[3]=0xFFFF00FF; collision=1 for exactly one cycle.
REQ-035 Read-first: port A writes 0x5 to address 9 (old value 0x3) while port B reads address 9 in the same cycle -> q_b returns 0x3; the next read returns 0x5.
REQ-036 Reset mid-clear: assert reset_n=0 at clear count 8, then release -> ready stays 0 for a full 2^AW cycles; user writes issued during CLEAR are not stored.

Source files
------------

// File: rtl/dpram_be_clr.sv
// Dual-port RAM with byte enables, read-first ports, collision flag and 1/2-cycle read latency.
// Define DPRAM_BE_CLR_CLEAR_EN to zero the whole array through port A after every reset.
module dpram_be_clr #(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              ready,
    input  logic              wren_a,
    input  logic [DW/8-1:0]   be_a,
    input  logic [AW-1:0]     address_a,
    input  logic [DW-1:0]     data_a,
    output logic [DW-1:0]     q_a,
    input  logic              wren_b,
    input  logic [DW/8-1:0]   be_b,
    input  logic [AW-1:0]     address_b,
    input  logic [DW-1:0]     data_b,
    output logic [DW-1:0]     q_b,
    output logic              collision
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem [2**AW];

    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [NB-1:0] wa_be;
    logic [DW-1:0] wa_data;
    logic          wb_en;

`ifdef DPRAM_BE_CLR_CLEAR_EN
    localparam logic CLEAR = 1'b0;
    localparam logic RUN   = 1'b1;

    logic          state;
    logic [AW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            count <= '0;
        end else if (state == CLEAR) begin
            count <= count + 1'b1;
            if (&count)
                state <= RUN;
        end
    end

    assign ready = (state == RUN);
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ready <= 1'b0;
        else
            ready <= 1'b1;
    end
`endif

    // While clearing, port A's write path is taken over by the counter.
    always_comb begin
        wa_en   = wren_a & ready;
        wa_addr = address_a;
        wa_be   = be_a;
        wa_data = data_a;
`ifdef DPRAM_BE_CLR_CLEAR_EN
        if (state == CLEAR) begin
            wa_en   = 1'b1;
            wa_addr = count;
            wa_be   = '1;
            wa_data = '0;
        end
`endif
    end

    assign wb_en = wren_b & ready;

    // Port A is applied after port B so it wins on shared lanes of a same-address write.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (wb_en && be_b[i])
                mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
            if (wa_en && wa_be[i])
                mem[wa_addr][8*i +: 8] <= wa_data[8*i +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            collision <= 1'b0;
        else
            collision <= wren_a & wren_b & ready & (address_a == address_b) & (|(be_a & be_b));
    end

    generate
        if (LAT == 2) begin : g_lat2
            logic [DW-1:0] rd_a;
            logic [DW-1:0] rd_b;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_a <= '0;
                    rd_b <= '0;
                    q_a  <= '0;
                    q_b  <= '0;
                end else begin
                    rd_a <= mem[address_a];
                    rd_b <= mem[address_b];
                    q_a  <= rd_a;
                    q_b  <= rd_b;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_a <= '0;
                    q_b <= '0;
                end else begin
                    q_a <= mem[address_a];
                    q_b <= mem[address_b];
                end
            end
        end
    endgenerate

endmodule
